// File: rtl/iq_downconv_if.sv
// rtl/iq_downconv_if.sv - IF sample input and baseband result bundle for iq_downconv.
interface iq_downconv_if #(
    parameter int DATA_W = 5,
    parameter int OUT_W  = 5
);
    logic                     ADC_rdy;
    logic signed [DATA_W-1:0] I_IF;
    logic signed [DATA_W-1:0] Q_IF;
    logic                     sync_clr;
    logic                     lo_dir;
    logic signed [OUT_W-1:0]  I_BB;
    logic signed [OUT_W-1:0]  Q_BB;
    logic                     demod_rdy;
    logic                     ovf;

    modport master (
        output ADC_rdy, I_IF, Q_IF, sync_clr, lo_dir,
        input  I_BB, Q_BB, demod_rdy, ovf
    );

    modport slave (
        input  ADC_rdy, I_IF, Q_IF, sync_clr, lo_dir,
        output I_BB, Q_BB, demod_rdy, ovf
    );
endinterface

// File: rtl/iq_downconv.sv
// rtl/iq_downconv.sv - fs/4 quadrature digital downconverter, two-stage pipeline.
// Define IQ_DOWNCONV_SAT_EN to saturate results (and report ovf) instead of wrapping.
module iq_downconv #(
    parameter int DATA_W = 5,
    parameter int OUT_W  = 5
) (
    input  logic          clk,
    input  logic          resetn,
    iq_downconv_if.slave  bus
);
    localparam int PW = DATA_W + 1;
    localparam int FW = DATA_W + 2;

    // LO coefficients are restricted to {+1, 0, -1}, encoded as 2-bit two's complement.
    typedef logic [1:0] coef_t;
    localparam coef_t C_POS  = 2'b01;
    localparam coef_t C_ZERO = 2'b00;
    localparam coef_t C_NEG  = 2'b11;

    function automatic logic signed [PW-1:0] mul_unit(
        input logic signed [DATA_W-1:0] x,
        input coef_t                    c
    );
        logic signed [PW-1:0] xe;
        xe = PW'(x);
        case (c)
            C_POS:   return xe;
            C_NEG:   return -xe;
            default: return '0;
        endcase
    endfunction

    logic [1:0] p;
    logic [1:0] lo_p;
    coef_t      cos_c;
    coef_t      sin_c;

    always_comb begin
        lo_p  = bus.sync_clr ? 2'd0 : p;
        cos_c = C_ZERO;
        sin_c = C_ZERO;
        case (lo_p)
            2'd0:    cos_c = C_POS;
            2'd1:    sin_c = C_POS;
            2'd2:    cos_c = C_NEG;
            default: sin_c = C_NEG;
        endcase
        if (bus.lo_dir) begin
            sin_c = -sin_c;
        end
    end

    // A restart without a sample parks the LO at phase 0 for the next sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p <= 2'd0;
        end else if (bus.ADC_rdy) begin
            p <= lo_p + 2'd1;
        end else begin
            p <= lo_p;
        end
    end

    logic signed [PW-1:0] s1_ic;
    logic signed [PW-1:0] s1_qs;
    logic signed [PW-1:0] s1_qc;
    logic signed [PW-1:0] s1_is;
    logic                 s1_vld;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_ic  <= '0;
            s1_qs  <= '0;
            s1_qc  <= '0;
            s1_is  <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= bus.ADC_rdy;
            if (bus.ADC_rdy) begin
                s1_ic <= mul_unit(bus.I_IF, cos_c);
                s1_qs <= mul_unit(bus.Q_IF, sin_c);
                s1_qc <= mul_unit(bus.Q_IF, cos_c);
                s1_is <= mul_unit(bus.I_IF, sin_c);
            end
        end
    end

    // Only one of cos/sin is nonzero per phase, so the negated sums cannot overflow FW bits.
    logic signed [FW-1:0] i_full;
    logic signed [FW-1:0] q_full;

    always_comb begin
        i_full = -(FW'(s1_ic) + FW'(s1_qs));
        q_full = -(FW'(s1_qc) - FW'(s1_is));
    end

    logic signed [OUT_W-1:0] i_red;
    logic signed [OUT_W-1:0] q_red;
    logic                    ovf_n;

`ifdef IQ_DOWNCONV_SAT_EN
    localparam int MAXV = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [FW-1:0]    SAT_MAX   = FW'(MAXV);
    localparam logic signed [FW-1:0]    SAT_MIN   = FW'(-MAXV - 1);
    localparam logic signed [OUT_W-1:0] SAT_MAX_O = OUT_W'(MAXV);
    localparam logic signed [OUT_W-1:0] SAT_MIN_O = OUT_W'(-MAXV - 1);

    function automatic logic signed [OUT_W-1:0] clamp(input logic signed [FW-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX_O;
        end else if (x < SAT_MIN) begin
            return SAT_MIN_O;
        end else begin
            return OUT_W'(x);
        end
    endfunction

    function automatic logic clamped(input logic signed [FW-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    always_comb begin
        i_red = clamp(i_full);
        q_red = clamp(q_full);
        ovf_n = clamped(i_full) || clamped(q_full);
    end
`else
    always_comb begin
        i_red = OUT_W'(i_full);
        q_red = OUT_W'(q_full);
        ovf_n = 1'b0;
    end
`endif

    logic signed [OUT_W-1:0] i_bb_q;
    logic signed [OUT_W-1:0] q_bb_q;
    logic                    rdy_q;
    logic                    ovf_q;

    // Result registers only load on a valid stage-1 entry, so they hold across gaps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_bb_q <= '0;
            q_bb_q <= '0;
            rdy_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            rdy_q <= s1_vld;
            if (s1_vld) begin
                i_bb_q <= i_red;
                q_bb_q <= q_red;
                ovf_q  <= ovf_n;
            end
        end
    end

    assign bus.I_BB      = i_bb_q;
    assign bus.Q_BB      = q_bb_q;
    assign bus.demod_rdy = rdy_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_iq_downconv.sv
// tb/tb_iq_downconv.sv - directed vector bench for iq_downconv.
module tb_iq_downconv;
    localparam int DATA_W = 5;
    localparam int OUT_W  = 5;

`ifdef IQ_DOWNCONV_SAT_EN
    localparam int SAT_I   = 15;
    localparam int SAT_OVF = 1;
`else
    localparam int SAT_I   = -16;
    localparam int SAT_OVF = 0;
`endif

    typedef struct {
        logic rdy;
        logic clr;
        logic dir;
        int   i;
        int   q;
        logic erdy;
        int   ei;
        int   eq;
        int   eovf;
    } vec_t;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    vec_t tv[$];

    iq_downconv_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    iq_downconv #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic clr, input logic dir, input int i, input int q,
                       input logic erdy, input int ei, input int eq, input int eovf);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.dir = dir; v.i = i; v.q = q;
        v.erdy = erdy; v.ei = ei; v.eq = eq; v.eovf = eovf;
        tv.push_back(v);
    endtask

    task automatic check_outs(input string name, input int idx, input logic erdy,
                              input int ei, input int eq, input int eovf);
        check({name, "_rdy"}, idx, int'(bus.demod_rdy), int'(erdy));
        check({name, "_i"},   idx, int'(bus.I_BB), ei);
        check({name, "_q"},   idx, int'(bus.Q_BB), eq);
        check({name, "_ovf"}, idx, int'(bus.ovf), eovf);
    endtask

    task automatic drive(input logic rdy, input logic clr, input logic dir, input int i, input int q);
        bus.ADC_rdy  = rdy;
        bus.sync_clr = clr;
        bus.lo_dir   = dir;
        bus.I_IF     = DATA_W'(i);
        bus.Q_IF     = DATA_W'(q);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0);

        // Each row: outputs expected at this negedge, then inputs applied for the next edge.
        //   rdy clr dir  I    Q   erdy  eI   eQ  eovf
        add(1, 0, 0,   3,   5,   0,    0,   0, 0);
        add(1, 0, 0,   3,   5,   0,    0,   0, 0);
        add(1, 0, 0,   3,   5,   1,   -3,  -5, 0);
        add(1, 0, 0,   3,   5,   1,   -5,   3, 0);
        add(0, 0, 0,   0,   0,   1,    3,   5, 0);
        add(0, 0, 0,   0,   0,   1,    5,  -3, 0);
        add(0, 0, 0,   0,   0,   0,    5,  -3, 0);
        add(1, 0, 1,   3,   5,   0,    5,  -3, 0);
        add(1, 0, 1,   3,   5,   0,    5,  -3, 0);
        add(1, 0, 1,   3,   5,   1,   -3,  -5, 0);
        add(1, 0, 1,   3,   5,   1,    5,  -3, 0);
        add(0, 0, 0,   0,   0,   1,    3,   5, 0);
        add(0, 0, 0,   0,   0,   1,   -5,   3, 0);
        add(1, 0, 0,   2,   0,   0,   -5,   3, 0);
        add(0, 0, 0,   0,   0,   0,   -5,   3, 0);
        add(0, 0, 0,   0,   0,   1,   -2,   0, 0);
        add(1, 0, 0,   2,   0,   0,   -2,   0, 0);
        add(0, 0, 0,   0,   0,   0,   -2,   0, 0);
        add(0, 0, 0,   0,   0,   1,    0,   2, 0);
        add(1, 1, 0,   4,   0,   0,    0,   2, 0);
        add(1, 0, 0,   3,   5,   0,    0,   2, 0);
        add(0, 0, 0,   0,   0,   1,   -4,   0, 0);
        add(0, 0, 0,   0,   0,   1,   -5,   3, 0);
        add(0, 0, 0,   0,   0,   0,   -5,   3, 0);
        add(0, 1, 0,   0,   0,   0,   -5,   3, 0);
        add(1, 0, 0, -16,   0,   0,   -5,   3, 0);
        add(0, 0, 0,   0,   0,   0,   -5,   3, 0);
        add(0, 0, 0,   0,   0,   1, SAT_I,  0, SAT_OVF);
        add(1, 0, 0,   1,   0,   0, SAT_I,  0, SAT_OVF);
        add(0, 0, 0,   0,   0,   0, SAT_I,  0, SAT_OVF);
        add(0, 0, 0,   0,   0,   1,    0,   1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 1'b0, 0, 0, 0);
        resetn = 1'b1;

        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clk);
            check_outs("vec", k, tv[k].erdy, tv[k].ei, tv[k].eq, tv[k].eovf);
            drive(tv[k].rdy, tv[k].clr, tv[k].dir, tv[k].i, tv[k].q);
        end

        // Reset asserted while a sample sits in stage 1: it must be discarded.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 3, 5);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        resetn = 1'b0;
        #1;
        check_outs("async_rst", 0, 1'b0, 0, 0, 0);
        @(negedge clk);
        check_outs("in_rst", 0, 1'b0, 0, 0, 0);
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_outs("flushed", k, 1'b0, 0, 0, 0);
        end
        drive(1'b1, 1'b0, 1'b0, 3, 5);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        check_outs("post_rst", 0, 1'b1, -3, -5, 0);
        @(negedge clk);
        check_outs("post_rst_hold", 0, 1'b0, -3, -5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
